mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_negate.sv | 15 +
 rtl/mult_div_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - default operand width
//   - op code constants on the op port
//   - FSM state encoding
package mdu_pkg;

  localparam int unsigned MduWidth = 32;
  localparam int unsigned CntWidth = 6;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negate.
//   en   - when 1, dout = -din; otherwise dout = din
//   din  - Width-bit operand
//   dout - Width-bit result
module mdu_negate #(
  parameter int unsigned Width = 32
) (
  input  logic             en,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  assign dout = en ? (~din + Width'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit.
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   start, op         - operation request and select (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   rs_data, rt_data  - multiplicand/dividend (or MTHI/MTLO data), multiplier/divisor
//   busy              - registered, high while an operation is in progress
//   done              - one-cycle pulse during the result-commit cycle
//   hi, lo            - HI/LO architectural registers
// Signed ops work on magnitudes; signs are latched at capture and applied in FIX.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MduWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned AccW = 2 * WIDTH + 1;

  mdu_state_e state_q, state_d;

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                is_div_q, is_div_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                busy_q;

  logic op_mul, op_div, op_signed, last_iter;

  assign op_mul    = (op == OpMult) || (op == OpMultu);
  assign op_div    = (op == OpDiv) || (op == OpDivu);
  assign op_signed = (op == OpMult) || (op == OpDiv);
  assign last_iter = (cnt_q == CntWidth'(WIDTH - 1));

  // Operand magnitudes for signed ops
  logic [WIDTH-1:0] rs_mag, rt_mag;

  mdu_negate #(.Width(WIDTH)) u_neg_rs (
    .en   (op_signed & rs_data[WIDTH-1]),
    .din  (rs_data),
    .dout (rs_mag)
  );

  mdu_negate #(.Width(WIDTH)) u_neg_rt (
    .en   (op_signed & rt_data[WIDTH-1]),
    .din  (rt_data),
    .dout (rt_mag)
  );

  // Shift-add step: acc = {carry, partial high, multiplier/low product}
  logic [WIDTH:0]   mul_sum;
  logic [AccW-1:0]  mul_step;

  assign mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, (acc_q[0] ? b_q : '0)};
  assign mul_step = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

  // Restoring-subtract step: acc = {remainder, dividend/quotient}, shifted left
  logic [WIDTH:0]   div_rem, div_diff;
  logic             div_ge;
  logic [AccW-1:0]  div_step;

  assign div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_rem >= {1'b0, b_q};
  assign div_diff = div_rem - {1'b0, b_q};
  assign div_step = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-1:0], 1'b0};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  mdu_negate #(.Width(2 * WIDTH)) u_neg_prod (
    .en   (q_neg_q),
    .din  (acc_q[2*WIDTH-1:0]),
    .dout (prod_fix)
  );

  mdu_negate #(.Width(WIDTH)) u_neg_quot (
    .en   (q_neg_q),
    .din  (acc_q[WIDTH-1:0]),
    .dout (quot_fix)
  );

  mdu_negate #(.Width(WIDTH)) u_neg_rem (
    .en   (r_neg_q),
    .din  (acc_q[2*WIDTH-1:WIDTH]),
    .dout (rem_fix)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && op_mul) begin
          state_d = StMul;
        end else if (start && op_div) begin
          state_d = StDiv;
        end
      end
      StMul, StDiv: begin
        if (last_iter) state_d = StFix;
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    done = (state_q == StFix);
  end

  // Datapath next state
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      StIdle: begin
        if (start && (op_mul || op_div)) begin
          cnt_d    = '0;
          is_div_d = op_div;
          // Divide by zero keeps the raw all-ones quotient unsigned
          q_neg_d  = op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]) & (rt_data != '0);
          r_neg_d  = op_signed & rs_data[WIDTH-1];
          b_d      = op_mul ? rs_mag : rt_mag;
          acc_d    = {{(WIDTH + 1){1'b0}}, (op_mul ? rt_mag : rs_mag)};
        end else if (start && (op == OpMthi)) begin
          hi_d = rs_data;
        end else if (start && (op == OpMtlo)) begin
          lo_d = rs_data;
        end
      end
      StMul: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CntWidth'(1);
      end
      StDiv: begin
        acc_d = div_step;
        cnt_d = cnt_q + CntWidth'(1);
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit (WIDTH = 32).
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one op; optionally re-assert start (MULTU 2 x 3) so it is sampled at edge E<inject>.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inject,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int ndone = 0;
    int nbusy = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);  // just after edge E<k>
      start = 1'b0;
      if (k + 1 == inject) begin
        start = 1'b1; op = 3'd1; rs_data = 32'd2; rt_data = 32'd3;
      end
      if (done) ndone++;
      if (busy !== (k < 33)) nbusy++;
      if (k == 32) begin
        check_eq({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, prev_hi});
        check_eq({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, prev_lo});
      end
    end
    check_eq({tag, "_done_cnt"}, 64'(ndone), 64'd1);
    check_eq({tag, "_busy_bad"}, 64'(nbusy), 64'd0);
    check_eq({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check_eq({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
    #12;
    check_eq("rst_hi",   {32'd0, hi}, 64'd0);
    check_eq("rst_lo",   {32'd0, lo}, 64'd0);
    check_eq("rst_busy", 64'(busy),   64'd0);
    check_eq("rst_done", 64'(done),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult_7x6",   3'd0, 32'd7,        32'd6,        -1, 32'h0,        32'd42);
    run_op("mult_m1m1",  3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'h0,        32'h1);
    run_op("multu_max",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'hFFFFFFFE, 32'h1);
    run_op("div_m7_2",   3'd2, 32'hFFFFFFF9, 32'd2,        -1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_5_0",   3'd3, 32'd5,        32'd0,        -1, 32'd5,        32'hFFFFFFFF);
    run_op("div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, -1, 32'h0,        32'h80000000);
    run_op("mult_ign",   3'd0, 32'd7,        32'd6,         5, 32'h0,        32'd42);

    // MTLO then MTHI in IDLE: immediate write, no busy, no done
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs_data = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    check_eq("mtlo_lo",   {32'd0, lo}, 64'h1234);
    check_eq("mtlo_hi",   {32'd0, hi}, 64'h0);
    check_eq("mtlo_busy", 64'(busy),   64'd0);
    check_eq("mtlo_done", 64'(done),   64'd0);
    start = 1'b1; op = 3'd4; rs_data = 32'hABCD;
    @(negedge clk);
    start = 1'b0;
    check_eq("mthi_hi",   {32'd0, hi}, 64'hABCD);
    check_eq("mthi_lo",   {32'd0, lo}, 64'h1234);
    check_eq("mthi_busy", 64'(busy),   64'd0);

    // Reset asserted mid-divide
    start = 1'b1; op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);  // after E0
    start = 1'b0;
    repeat (9) @(negedge clk);  // after E9
    @(posedge clk);  // E10
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_hi",   {32'd0, hi}, 64'd0);
    check_eq("abort_lo",   {32'd0, lo}, 64'd0);
    check_eq("abort_busy", 64'(busy),   64'd0);
    check_eq("abort_done", 64'(done),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_hi = '0;
    prev_lo = '0;
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, -1, 32'd2, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
